// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data memory / memory-mapped I/O block:
// I/O map offsets, region enum and the address decoder.
package dmem_io_pkg;

    localparam int OFF_IN     = 0;
    localparam int OFF_OUT    = 8;
    localparam int OFF_STATUS = 12;
    localparam int OFF_CNT    = 13;
    localparam int MAP_WORDS  = 16;

    typedef enum logic [2:0] {
        RAM,
        IN,
        OUT,
        STATUS,
        CNT,
        NONE
    } region_t;

    // Offsets past the 16-word I/O window fall through to NONE.
    function automatic region_t addr_decode(
        input logic [31:0] addr,
        input logic [31:0] io_base,
        input int          num_in,
        input int          num_out
    );
        logic [31:0] off;
        if (addr < io_base) return RAM;
        off = addr - io_base;
        if (off < 32'(OFF_IN + num_in)) return IN;
        if (off >= 32'(OFF_OUT) && off < 32'(OFF_OUT + num_out)) return OUT;
        if (off == 32'(OFF_STATUS)) return STATUS;
        if (off == 32'(OFF_CNT)) return CNT;
        return NONE;
    endfunction

endpackage

// File: rtl/io_in_sync.sv
// Two-flop synchroniser for one input port plus a "prev" flop; flags a
// change whenever the synchronised value differs from the previous one.
module io_in_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] value,
    output logic         changed
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign value   = sync2;
    assign changed = (sync2 != prev);

endmodule

// File: rtl/dmem_io_ctrl.sv
// CPU data memory with a 16-word memory-mapped I/O window at IO_BASE:
// synchronised inputs, sticky change STATUS, strobed outputs and a loadable counter.
module dmem_io_ctrl
    import dmem_io_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_IN   = 3,
    parameter int NUM_OUT  = 4,
    parameter int IO_BASE  = 32'hF0,
    parameter bit REG_READ = 1'b0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [ADDR_W-1:0]         ADDR,
    input  logic [DATA_W-1:0]         DATA,
    input  logic                      MW,
    input  logic                      RD,
    output logic [DATA_W-1:0]         Q,
    input  logic [NUM_IN*DATA_W-1:0]  IO_IN,
    output logic [NUM_OUT*DATA_W-1:0] IO_OUT,
    output logic [NUM_OUT-1:0]        IO_OUT_STB
);

    localparam int RAM_AW = $clog2(IO_BASE);

    region_t            region;
    logic [3:0]         off;
    logic [DATA_W-1:0]  mem [IO_BASE];
    logic [DATA_W-1:0]  in_val [NUM_IN];
    logic [NUM_IN-1:0]  in_chg;
    logic [NUM_IN-1:0]  status;
    logic               status_clr;
    logic [DATA_W-1:0]  out_reg [NUM_OUT];
    logic [NUM_OUT-1:0] out_wr;
    logic [NUM_OUT-1:0] out_stb;
    logic [DATA_W-1:0]  cnt;
    logic               cnt_load;
    logic [DATA_W-1:0]  rd_data;

    // IO_BASE is 16-word aligned, so the low address nibble is the map offset.
    assign region     = addr_decode(32'(ADDR), 32'(IO_BASE), NUM_IN, NUM_OUT);
    assign off        = ADDR[3:0];
    assign status_clr = RD && (region == STATUS);
    assign cnt_load   = MW && (region == CNT);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        io_in_sync #(.W(DATA_W)) u_sync (
            .clk      (CLK),
            .reset    (RESET),
            .async_in (IO_IN[i*DATA_W +: DATA_W]),
            .value    (in_val[i]),
            .changed  (in_chg[i])
        );
    end

    always_comb begin
        out_wr = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            out_wr[j] = MW && (region == OUT) && (off == 4'(OFF_OUT + j));
        end
    end

    always_ff @(posedge CLK) begin
        if (MW && region == RAM) begin
            mem[ADDR[RAM_AW-1:0]] <= DATA;
        end
    end

    // A change seen in the same cycle as the clearing read keeps its bit set.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            status  <= '0;
            cnt     <= '0;
            out_stb <= '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                out_reg[j] <= '0;
            end
        end else begin
            status  <= in_chg | (status & ~{NUM_IN{status_clr}});
            cnt     <= cnt_load ? DATA : cnt + DATA_W'(1);
            out_stb <= out_wr;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (out_wr[j]) begin
                    out_reg[j] <= DATA;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (region)
            RAM: rd_data = mem[ADDR[RAM_AW-1:0]];
            IN: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (off == 4'(OFF_IN + i)) rd_data = in_val[i];
                end
            end
            OUT: begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    if (off == 4'(OFF_OUT + j)) rd_data = out_reg[j];
                end
            end
            STATUS:  rd_data[NUM_IN-1:0] = status;
            CNT:     rd_data = cnt;
            default: rd_data = '0;
        endcase
    end

    if (REG_READ) begin : g_reg_read
        logic [DATA_W-1:0] q_reg;
        always_ff @(posedge CLK) begin
            if (!RESET) q_reg <= '0;
            else        q_reg <= rd_data;
        end
        assign Q = q_reg;
    end else begin : g_comb_read
        assign Q = rd_data;
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        assign IO_OUT[j*DATA_W +: DATA_W] = out_reg[j];
    end
    assign IO_OUT_STB = out_stb;

endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Directed bench for dmem_io_ctrl: one combinational-read and one registered-read
// instance share stimulus; expected read data is queued per access and popped on output.
module tb_dmem_io_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NI = 3;
    localparam int NO = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic [DW-1:0]    data = '0;
    logic             mw = 1'b0;
    logic             rd = 1'b0;
    logic [NI*DW-1:0] io_in = '0;
    logic [DW-1:0]    q_c;
    logic [DW-1:0]    q_r;
    logic [NO*DW-1:0] io_out_c;
    logic [NO*DW-1:0] io_out_r;
    logic [NO-1:0]    stb_c;
    logic [NO-1:0]    stb_r;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_r_q[$];
    string         tag_q[$];

    dmem_io_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_IN(NI), .NUM_OUT(NO),
                   .IO_BASE(32'hF0), .REG_READ(1'b0)) u_dut_c (
        .CLK(clk), .RESET(reset_n), .ADDR(addr), .DATA(data), .MW(mw), .RD(rd),
        .Q(q_c), .IO_IN(io_in), .IO_OUT(io_out_c), .IO_OUT_STB(stb_c)
    );

    dmem_io_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_IN(NI), .NUM_OUT(NO),
                   .IO_BASE(32'hF0), .REG_READ(1'b1)) u_dut_r (
        .CLK(clk), .RESET(reset_n), .ADDR(addr), .DATA(data), .MW(mw), .RD(rd),
        .Q(q_r), .IO_IN(io_in), .IO_OUT(io_out_r), .IO_OUT_STB(stb_r)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One bus cycle, entered and left at a falling edge. Combinational Q is
    // checked 1 ns into the cycle, registered Q at the next falling edge.
    task automatic op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic w, input logic r,
                      input logic chk, input logic [DW-1:0] e, input string tag);
        addr = a;
        data = d;
        mw   = w;
        rd   = r;
        if (chk) begin
            exp_q.push_back(e);
            exp_r_q.push_back(e);
            tag_q.push_back(tag);
        end
        #1;
        if (chk) check({tag, "/comb"}, 32'(q_c), 32'(exp_q.pop_front()));
        @(negedge clk);
        mw = 1'b0;
        rd = 1'b0;
        if (chk) check({tag_q.pop_front(), "/reg"}, 32'(q_r), 32'(exp_r_q.pop_front()));
    endtask

    initial begin
        // Reset: held low for three rising edges
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_io_out", 32'(io_out_c), 32'h0);
        check("rst_stb", 32'(stb_c), 32'h0);
        check("rst_q_reg", 32'(q_r), 32'h0);
        reset_n = 1'b1;

        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "cnt0");
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, "cnt1");
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, "cnt2");
        op(8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "status_rst");

        // RAM, including read-during-write and an I/O-address write
        op(8'h00, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, "ram0_wr");
        op(8'h10, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, "ram10_wr");
        op(8'h10, 8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, "ram_rdw");
        op(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, "ram10_rd");
        op(8'hEF, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, "ramef_wr");
        op(8'hEF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, "ramef_rd");
        op(8'hF0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, "wr_in_ignored");
        op(8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "in0_still0");
        op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, "ram0_kept");
        op(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, "ram10_kept");
        op(8'hEF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, "ramef_kept");

        // Input 1 change: readable after 2 edges, STATUS one edge later
        io_in[1*DW +: DW] = 8'h7E;
        op(8'hF1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "in1_c0");
        op(8'hF1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "in1_c1");
        op(8'hF1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7E, "in1_c2");
        op(8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, "status_set");
        op(8'hFC, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, "status_rdclr");
        op(8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "status_cleared");

        // Input 0 change detected in the same cycle as the clearing read
        io_in[0*DW +: DW] = 8'h01;
        op(8'hFE, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "none_rd0");
        op(8'hFE, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "none_rd1");
        op(8'hFC, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, "sw_preclear");
        op(8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, "set_wins");
        op(8'hFC, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, "status_wr_rd");
        op(8'hFC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "status_wr_ignored");

        // Output registers and strobes
        op(8'hF9, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, "out1_wr");
        check("out1_val", 32'(io_out_c[1*DW +: DW]), 32'h55);
        check("stb_pulse", 32'(stb_c), 32'h2);
        op(8'hF9, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, "out1_rd");
        check("stb_drop", 32'(stb_c), 32'h0);
        op(8'hFA, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, "out2_wr_a");
        check("stb2_c1", 32'(stb_c), 32'h4);
        op(8'hFA, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, "out2_wr_b");
        check("stb2_c2", 32'(stb_c), 32'h4);
        check("out2_val", 32'(io_out_c[2*DW +: DW]), 32'h22);
        op(8'hFE, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00, "none_wr");
        check("stb2_drop", 32'(stb_c), 32'h0);
        check("out_all", 32'(io_out_c), 32'h0022_5500);

        // Counter load, wrap and mid-count reset
        op(8'hFD, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h00, "cnt_ld");
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFE, "cnt_fe");
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, "cnt_ff");
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "cnt_wrap");
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, "cnt_after_wrap");
        reset_n = 1'b0;
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "cnt_in_rst");
        reset_n = 1'b1;
        check("rst_mid_io_out", 32'(io_out_c), 32'h0);
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "cnt_rst");
        op(8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, "cnt_rst_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
